polyvec_basemul_ctrl: RTL and testbench

POLYVEC_BASEMUL_CTRL -- requirements
Module: polyvec_basemul_ctrl

---
 rtl/polyvec_basemul_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_polyvec_basemul_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyvec_basemul_ctrl.sv
// polyvec_basemul_ctrl
// Sequences a polynomial base-multiplication engine over K rows per job:
// clear the engine, let it compute, then stream its 2^DEPTH result words
// out through a valid/ready register stage tagged with row and index.
// Optional build macro: PVBM_CTRL_TIMEOUT_EN adds a RUN-state watchdog
// that aborts to ERR when eng_done does not arrive within 4095 cycles.
module polyvec_basemul_ctrl #(
  parameter int DEPTH = 5,
  parameter int K     = 3
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       row_sel_o,
  output logic             eng_clr_o,
  output logic             eng_set_o,
  output logic             eng_readout_o,
  input  logic [15:0]      eng_dout_1_i,
  input  logic [15:0]      eng_dout_2_i,
  input  logic [DEPTH-1:0] eng_out_index_i,
  input  logic             eng_done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_1_o,
  output logic [15:0]      out_data_2_o,
  output logic [1:0]       out_row_o,
  output logic [DEPTH-1:0] out_index_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_READ   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam logic [1:0]     LAST_ROW = 2'(K - 1);
  localparam logic [DEPTH:0] CNT_ONE  = (DEPTH + 1)'(1);

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [DEPTH:0]   cnt_q, cnt_d;      // words read from the engine this row
  logic             rd_s;              // readout strobe for this cycle
  logic             accept_s;          // output stage can take a new word
  logic             tmo_hit_s;         // watchdog expiry in RUN

  logic             busy_q, done_q, clr_q, set_q;
  logic             ov_q, ov_d;
  logic [15:0]      od1_q, od1_d, od2_q, od2_d;
  logic [1:0]       orow_q, orow_d;
  logic [DEPTH-1:0] oidx_q, oidx_d;

  assign accept_s = (~ov_q) | out_ready_i;

`ifdef PVBM_CTRL_TIMEOUT_EN
  logic [11:0] tmo_q, tmo_d;
  logic        err_q;

  // Watchdog: counts cycles spent in RUN, cleared in every other state.
  always_comb begin
    tmo_d = 12'd0;
    if (state_q == S_RUN) begin
      tmo_d = tmo_q + 12'd1;
    end else begin
      tmo_d = 12'd0;
    end
  end

  // Expiry fires on the 4095th RUN cycle without eng_done.
  assign tmo_hit_s = (tmo_q == 12'd4094);

  // Watchdog counter and error flag registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tmo_q <= 12'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= (state_d == S_ERR);
    end
  end

  assign err_o = err_q;
`else
  assign tmo_hit_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Next-state, row, word-counter and readout-strobe decode.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    rd_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          row_d   = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (eng_done_i) begin
          state_d = S_READ;
        end else if (tmo_hit_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_RUN;
        end
      end
      S_READ: begin
        // The top counter bit marks that all 2^DEPTH words have been read.
        rd_s = accept_s & ~cnt_q[DEPTH];
        if (rd_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (cnt_q[DEPTH] && accept_s) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_READ;
        end
      end
      S_NEXT: begin
        if (row_q < LAST_ROW) begin
          row_d   = row_q + 2'd1;
          state_d = S_CLEAR;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        // start is deliberately not looked at here.
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (start_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, row and counter registers; control outputs registered from next state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
      clr_q   <= (state_d == S_CLEAR);
      set_q   <= (state_d == S_RUN);
    end
  end

  // Output stage: load on readout, drop valid once accepted, hold while stalled.
  always_comb begin
    ov_d   = ov_q;
    od1_d  = od1_q;
    od2_d  = od2_q;
    orow_d = orow_q;
    oidx_d = oidx_q;
    if (rd_s) begin
      ov_d   = 1'b1;
      od1_d  = eng_dout_1_i;
      od2_d  = eng_dout_2_i;
      orow_d = row_q;
      oidx_d = eng_out_index_i;
    end else if (out_ready_i) begin
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
  end

  // Output stage registers; reset discards any pending word.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ov_q   <= 1'b0;
      od1_q  <= 16'd0;
      od2_q  <= 16'd0;
      orow_q <= 2'd0;
      oidx_q <= '0;
    end else begin
      ov_q   <= ov_d;
      od1_q  <= od1_d;
      od2_q  <= od2_d;
      orow_q <= orow_d;
      oidx_q <= oidx_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign row_sel_o     = row_q;
  assign eng_clr_o     = clr_q;
  assign eng_set_o     = set_q;
  assign eng_readout_o = rd_s;
  assign out_valid_o   = ov_q;
  assign out_data_1_o  = od1_q;
  assign out_data_2_o  = od2_q;
  assign out_row_o     = orow_q;
  assign out_index_o   = oidx_q;

endmodule

// File: tb/tb_polyvec_basemul_ctrl.sv
// Self-checking bench for polyvec_basemul_ctrl: a K=3/DEPTH=5 instance driven
// by a job table plus corner sequences, and a K=1/DEPTH=2 instance.
module tb_polyvec_basemul_ctrl;

  localparam int DA = 5;
  localparam int KA = 3;
  localparam int NA = (1 << DA) * KA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_pass = 0;
  int   n_checks = 0;

  // instance A signals
  logic          a_start, a_busy, a_done, a_clr, a_set, a_rd, a_eng_done;
  logic          a_ov, a_ordy, a_err;
  logic [1:0]    a_row_sel, a_out_row;
  logic [15:0]   a_d1, a_d2, a_od1, a_od2;
  logic [DA-1:0] a_eidx, a_oidx;
  // instance B signals
  logic          b_start, b_busy, b_done, b_clr, b_set, b_rd, b_eng_done;
  logic          b_ov, b_ordy, b_err;
  logic [1:0]    b_row_sel, b_out_row;
  logic [15:0]   b_d1, b_d2, b_od1, b_od2;
  logic [1:0]    b_eidx, b_oidx;

  function automatic logic [15:0] f1(input logic [1:0] r, input logic [4:0] i);
    return 16'h00A5 + ({11'd0, i} * 16'd7) + {r, 14'd0};
  endfunction

  function automatic logic [15:0] f2(input logic [1:0] r, input logic [4:0] i);
    return (~f1(r, i)) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  polyvec_basemul_ctrl #(.DEPTH(DA), .K(KA)) u_a (
    .clk_i(clk), .reset_ni(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .row_sel_o(a_row_sel), .eng_clr_o(a_clr), .eng_set_o(a_set), .eng_readout_o(a_rd),
    .eng_dout_1_i(a_d1), .eng_dout_2_i(a_d2), .eng_out_index_i(a_eidx),
    .eng_done_i(a_eng_done), .out_valid_o(a_ov), .out_ready_i(a_ordy),
    .out_data_1_o(a_od1), .out_data_2_o(a_od2), .out_row_o(a_out_row),
    .out_index_o(a_oidx), .err_o(a_err)
  );

  polyvec_basemul_ctrl #(.DEPTH(2), .K(1)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .row_sel_o(b_row_sel), .eng_clr_o(b_clr), .eng_set_o(b_set), .eng_readout_o(b_rd),
    .eng_dout_1_i(b_d1), .eng_dout_2_i(b_d2), .eng_out_index_i(b_eidx),
    .eng_done_i(b_eng_done), .out_valid_o(b_ov), .out_ready_i(b_ordy),
    .out_data_1_o(b_od1), .out_data_2_o(b_od2), .out_row_o(b_out_row),
    .out_index_o(b_oidx), .err_o(b_err)
  );

  // Engine models: count set cycles after a clear, step the readout index.
  int   a_setcnt, b_setcnt;
  int   a_delay = 10;
  logic a_hang = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_setcnt <= 0; a_eidx <= '0; b_setcnt <= 0; b_eidx <= '0;
    end else begin
      if (a_clr) begin
        a_setcnt <= 0; a_eidx <= '0;
      end else begin
        if (a_set) a_setcnt <= a_setcnt + 1;
        if (a_rd)  a_eidx <= a_eidx + 5'd1;
      end
      if (b_clr) begin
        b_setcnt <= 0; b_eidx <= '0;
      end else begin
        if (b_set) b_setcnt <= b_setcnt + 1;
        if (b_rd)  b_eidx <= b_eidx + 2'd1;
      end
    end
  end

  assign a_eng_done = !a_hang && (a_setcnt >= a_delay);
  assign b_eng_done = (b_setcnt >= 2);
  assign a_d1 = f1(a_row_sel, a_eidx);
  assign a_d2 = f2(a_row_sel, a_eidx);
  assign b_d1 = f1(b_row_sel, {3'd0, b_eidx});
  assign b_d2 = f2(b_row_sel, {3'd0, b_eidx});
  assign b_ordy = 1'b1;

  // Scoreboard of expected words for instance A.
  typedef struct packed {
    logic [1:0]    row;
    logic [DA-1:0] idx;
    logic [15:0]   d1;
    logic [15:0]   d2;
  } word_t;
  word_t sb[$];

  task automatic push_job();
    for (int r = 0; r < KA; r++)
      for (int i = 0; i < (1 << DA); i++) begin
        word_t w;
        w.row = 2'(r); w.idx = 5'(i);
        w.d1 = f1(2'(r), 5'(i)); w.d2 = f2(2'(r), 5'(i));
        sb.push_back(w);
      end
  endtask

  // out_ready driver: steady 1 or toggling every cycle.
  bit rdy_tog = 1'b0;
  initial begin
    a_ordy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_tog) a_ordy = ~a_ordy;
      else a_ordy = 1'b1;
    end
  end

  // Monitor: handshakes, stall stability, done pulse shape, B bookkeeping.
  int a_words = 0, a_dones = 0, b_words = 0, b_dones = 0, b_clrs = 0;
  logic [1:0] b_exp_idx = 2'd0;
  initial begin
    bit stall_pend = 1'b0;
    bit prev_done = 1'b0;
    logic [38:0] snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0; prev_done = 1'b0;
      end else begin
        if (stall_pend && a_ov)
          chk("stall_stable", 64'({a_out_row, a_oidx, a_od1, a_od2}), 64'(snap));
        stall_pend = a_ov && !a_ordy;
        snap = {a_out_row, a_oidx, a_od1, a_od2};
        if (a_ov && a_ordy) begin
          a_words++;
          if (sb.size() == 0) chk("sb_underflow", 64'(a_words), 64'd0);
          else begin
            word_t w;
            w = sb.pop_front();
            chk("a_word", 64'({a_out_row, a_oidx, a_od1, a_od2}), 64'(w));
          end
        end
        if (prev_done) chk("after_done_busy_done", 64'({a_busy, a_done}), 64'd0);
        if (a_done) begin
          a_dones++;
          chk("busy_with_done", 64'(a_busy), 64'd1);
        end
        prev_done = a_done;
        if (b_ov && b_ordy) begin
          chk("b_word", 64'({b_out_row, b_oidx, b_od1, b_od2}),
              64'({2'd0, b_exp_idx, f1(2'd0, {3'd0, b_exp_idx}), f2(2'd0, {3'd0, b_exp_idx})}));
          b_exp_idx = b_exp_idx + 2'd1;
          b_words++;
        end
        if (b_clr) b_clrs++;
        if (b_done) b_dones++;
      end
    end
  end

  task automatic start_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n = i + 1;
      if (a_done) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    bit tog;
    int delay;
    int exp_lat;   // negedges from start to done; 0 = not checked
  } job_t;
  job_t jobs[4];

  initial begin
    bit ok;
    int n, w0, d0;
    jobs[0] = '{tog: 1'b0, delay: 10, exp_lat: 3 * (10 + 36) + 1};
    jobs[1] = '{tog: 1'b1, delay: 10, exp_lat: 0};
    jobs[2] = '{tog: 1'b0, delay: 1,  exp_lat: 3 * (1 + 36) + 1};
    jobs[3] = '{tog: 1'b1, delay: 3,  exp_lat: 0};
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", 64'({a_busy, a_done, a_err, a_clr, a_set, a_rd, a_ov, a_od1, a_od2,
                        a_out_row, a_oidx, a_row_sel}), 64'd0);
    chk("reset_b", 64'({b_busy, b_done, b_err, b_clr, b_set, b_rd, b_ov, b_od1, b_od2,
                        b_out_row, b_oidx, b_row_sel}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Job table.
    for (int j = 0; j < 4; j++) begin
      rdy_tog = jobs[j].tog; a_delay = jobs[j].delay;
      push_job();
      w0 = a_words; d0 = a_dones;
      start_a();
      wait_done_a(2000, ok, n);
      chk("job_done", 64'(ok), 64'd1);
      if (jobs[j].exp_lat != 0) chk("job_latency", 64'(n), 64'(jobs[j].exp_lat));
      repeat (5) @(negedge clk);
      chk("job_words", 64'(a_words - w0), 64'(NA));
      chk("job_dones", 64'(a_dones - d0), 64'd1);
      chk("job_sb_empty", 64'(sb.size()), 64'd0);
      chk("job_idle", 64'(a_busy), 64'd0);
    end

    // start pulsed during RUN of row 1 is ignored.
    rdy_tog = 1'b0; a_delay = 10;
    push_job();
    w0 = a_words; d0 = a_dones;
    start_a();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (a_set && a_row_sel == 2'd1) begin ok = 1'b1; break; end
    end
    chk("reach_run_row1", 64'(ok), 64'd1);
    #1 a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done_a(2000, ok, n);
    chk("busy_start_done", 64'(ok), 64'd1);
    repeat (200) @(negedge clk);
    chk("busy_start_dones", 64'(a_dones - d0), 64'd1);
    chk("busy_start_words", 64'(a_words - w0), 64'(NA));
    chk("busy_start_idle", 64'(a_busy), 64'd0);

    // Instance B: K=1, DEPTH=2.
    b_exp_idx = 2'd0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_done) begin ok = 1'b1; break; end
    end
    chk("b_done_seen", 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    chk("b_words", 64'(b_words), 64'd4);
    chk("b_clrs", 64'(b_clrs), 64'd1);
    chk("b_dones", 64'(b_dones), 64'd1);
    chk("b_idle", 64'(b_busy), 64'd0);

    // Asynchronous reset during READ of row 1, word 7.
    push_job();
    d0 = a_dones;
    start_a();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (a_rd && a_row_sel == 2'd1 && a_eidx == 5'd7) begin ok = 1'b1; break; end
    end
    chk("reach_read_r1w7", 64'(ok), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 64'({a_busy, a_done, a_err, a_clr, a_set, a_rd, a_ov, a_od1, a_od2,
                                a_out_row, a_oidx, a_row_sel}), 64'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_no_done", 64'(a_dones - d0), 64'd0);
    push_job();
    w0 = a_words; d0 = a_dones;
    start_a();
    wait_done_a(2000, ok, n);
    chk("restart_done", 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    chk("restart_words", 64'(a_words - w0), 64'(NA));
    chk("restart_dones", 64'(a_dones - d0), 64'd1);

    // Engine never finishes.
    a_hang = 1'b1;
    d0 = a_dones;
    start_a();
`ifdef PVBM_CTRL_TIMEOUT_EN
    ok = 1'b0; n = 0;
    for (int i = 0; i < 4300; i++) begin
      @(negedge clk);
      n = i + 1;
      if (a_err) begin ok = 1'b1; break; end
    end
    chk("tmo_err", 64'(ok), 64'd1);
    chk("tmo_latency_ok", 64'((n >= 4090) && (n <= 4100)), 64'd1);
    chk("tmo_busy", 64'(a_busy), 64'd1);
    chk("tmo_no_done", 64'(a_dones - d0), 64'd0);
    a_hang = 1'b0;
    start_a();
    chk("tmo_err_clear", 64'({a_err, a_busy}), 64'd0);
`else
    repeat (4300) @(negedge clk);
    chk("hang_busy", 64'(a_busy), 64'd1);
    chk("hang_err", 64'(a_err), 64'd0);
    chk("hang_no_done", 64'(a_dones - d0), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_hang = 1'b0;
    @(negedge clk);
    chk("hang_reset_idle", 64'({a_err, a_busy}), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
